// File: rtl/lsu_mem_sequencer.sv
// Handshaked multicycle load/store sequencer between the control FSM and data memory.
// Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them down.
module lsu_mem_sequencer #(
  parameter int XLEN     = 64,
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]   wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              regwrite,
  output logic [XLEN-1:0]   rd_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN/8-1:0] mem_wstrb,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ready
);
  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t            state_r, next_state_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              we_r, err_r;
  logic [2:0]        funct3_r;
  logic [OFF_W-1:0]  off_r;
  logic [ADDR_W-1:0] addr_r;
  logic [NB-1:0]     wstrb_r;
  logic [XLEN-1:0]   wdata_r, rd_data_r;
  logic [OFF_W-1:0]  align_s, off_s;
  logic              misalign_s, bad_s, timeout_s;

  function automatic logic illegal_op(input logic st, input logic [2:0] f3);
    logic bad;
    bad = st ? f3[2] : (f3 == 3'b111);
    if (XLEN == 32 && (f3 == 3'b011 || f3 == 3'b110)) bad = 1'b1;
    else bad = bad;
    return bad;
  endfunction

  function automatic logic [NB-1:0] lane_mask(input logic [1:0] sz);
    logic [7:0] m;
    case (sz)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m[NB-1:0];
  endfunction

  function automatic logic [OFF_W-1:0] align_mask(input logic [1:0] sz);
    logic [2:0] m;
    case (sz)
      2'd0:    m = 3'd0;
      2'd1:    m = 3'd1;
      2'd2:    m = 3'd3;
      default: m = 3'd7;
    endcase
    return m[OFF_W-1:0];
  endfunction

  // Move the selected lane to the top, then shift back down arithmetically or logically.
  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] raw, input logic [2:0] f3);
    logic [XLEN-1:0] up;
    int sh;
    case (f3[1:0])
      2'd0:    sh = XLEN - 8;
      2'd1:    sh = XLEN - 16;
      2'd2:    sh = XLEN - 32;
      default: sh = 0;
    endcase
    up = raw << sh;
    if (f3[2]) return up >> sh;
    else return $signed(up) >>> sh;
  endfunction

  // Request decode: legality, alignment and effective lane offset.
  always_comb begin
    align_s    = align_mask(funct3[1:0]);
    misalign_s = |(addr[OFF_W-1:0] & align_s);
    off_s      = addr[OFF_W-1:0] & ~align_s;
`ifdef LSU_MISALIGN_TRAP_EN
    bad_s      = illegal_op(is_store, funct3) | misalign_s;
`else
    bad_s      = illegal_op(is_store, funct3);
`endif
    timeout_s  = (cnt_r == CNT_W'(MAX_WAIT - 1));
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= IDLE;
    else state_r <= next_state_s;
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) next_state_s = bad_s ? RESP : ACCESS;
        else next_state_s = IDLE;
      end
      ACCESS: begin
        if (mem_ready || timeout_s) next_state_s = RESP;
        else next_state_s = ACCESS;
      end
      RESP:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Request latch, wait counter and load-result capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r     <= '0;
      we_r      <= 1'b0;
      err_r     <= 1'b0;
      funct3_r  <= 3'b000;
      off_r     <= '0;
      addr_r    <= '0;
      wstrb_r   <= '0;
      wdata_r   <= '0;
      rd_data_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_r <= '0;
          if (start) begin
            we_r     <= is_store;
            err_r    <= bad_s;
            funct3_r <= funct3;
            off_r    <= off_s;
            addr_r   <= {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            wstrb_r  <= lane_mask(funct3[1:0]) << off_s;
            wdata_r  <= wr_data << {off_s, 3'b000};
          end
        end
        ACCESS: begin
          cnt_r <= cnt_r + CNT_W'(1);
          if (mem_ready) begin
            if (!we_r) rd_data_r <= extend(mem_rdata >> {off_r, 3'b000}, funct3_r);
          end else if (timeout_s) begin
            err_r <= 1'b1;
          end
        end
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Output decode from the state register and latched request.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    regwrite  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wstrb = '0;
    mem_wdata = '0;
    rd_data   = rd_data_r;
    case (state_r)
      ACCESS: begin
        busy      = 1'b1;
        mem_en    = 1'b1;
        mem_we    = we_r;
        mem_addr  = addr_r;
        mem_wstrb = wstrb_r;
        mem_wdata = wdata_r;
      end
      RESP: begin
        busy     = 1'b1;
        done     = 1'b1;
        err      = err_r;
        regwrite = ~err_r & ~we_r;
      end
      default: busy = 1'b0;
    endcase
  end
endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// Self-checking bench for lsu_mem_sequencer: directed cases plus randomized traffic
// checked against an arithmetic reference model.
module tb_lsu_mem_sequencer;
  localparam int MAX_WAIT = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, is_store, mem_ready;
  logic [2:0]  funct3;
  logic [31:0] addr, mem_addr;
  logic [63:0] wr_data, rd_data, mem_wdata, mem_rdata;
  logic        busy, done, err, regwrite, mem_en, mem_we;
  logic [7:0]  mem_wstrb;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_rd = 64'd0;
  int          en_cycles;
  logic [31:0] last_addr;
  logic [7:0]  last_strb;
  logic [63:0] last_wdata;
  logic        last_we;

  lsu_mem_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wr_data(wr_data), .busy(busy), .done(done), .err(err),
    .regwrite(regwrite), .rd_data(rd_data), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_illegal(input bit st, input bit [2:0] f3);
    if (st) return f3[2];
    return f3 == 3'b111;
  endfunction

  function automatic int model_size(input bit [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] rdat, input bit [2:0] f3, input int off);
    int sz;
    logic [63:0] v, mask;
    sz = model_size(f3);
    v = rdat >> (8 * off);
    if (sz < 8) begin
      mask = (64'd1 << (8 * sz)) - 64'd1;
      v = v & mask;
      if (!f3[2] && v[8 * sz - 1]) v = v | ~mask;
    end
    return v;
  endfunction

  // One complete transaction; lat<0 means memory never answers.
  task automatic do_txn(input bit st, input bit [2:0] f3, input logic [31:0] a,
                        input logic [63:0] wd, input logic [63:0] rdat, input int lat,
                        input bit noise, input string tag);
    bit bad, tmo;
    int sz, off, exp_cycles;
    logic [7:0] exp_strb;
    logic [63:0] exp_wd;
    bad = model_illegal(st, f3);
`ifdef LSU_MISALIGN_TRAP_EN
    bad = bad || ((a % model_size(f3)) != 0);
`endif
    sz = model_size(f3);
    off = int'(a % 32'd8);
    off = off - (off % sz);
    exp_strb = 8'(((1 << sz) - 1) << off);
    exp_wd = wd << (8 * off);
    start = 1'b1; is_store = st; funct3 = f3; addr = a; wr_data = wd;
    tick();
    start = 1'b0; is_store = 1'($urandom); funct3 = 3'($urandom); addr = $urandom;
    wr_data = {$urandom, $urandom};
    en_cycles = 0;
    last_we = 1'b0;
    if (!bad) begin
      while (done !== 1'b1 && en_cycles < 40) begin
        n_checks++;
        if (mem_en !== 1'b1 || busy !== 1'b1 || mem_we !== st) begin
          n_errors++;
          $display("FAIL %s access: en=%b busy=%b we=%b expected 1 1 %b", tag, mem_en, busy, mem_we, st);
        end
        n_checks++;
        if (mem_addr !== {a[31:3], 3'b000}) begin
          n_errors++;
          $display("FAIL %s mem_addr: got %h expected %h", tag, mem_addr, {a[31:3], 3'b000});
        end
        if (st) begin
          n_checks++;
          if (mem_wstrb !== exp_strb || mem_wdata !== exp_wd) begin
            n_errors++;
            $display("FAIL %s store lanes: strb=%h wdata=%h expected %h %h", tag, mem_wstrb, mem_wdata, exp_strb, exp_wd);
          end
        end
        last_addr = mem_addr; last_strb = mem_wstrb; last_wdata = mem_wdata; last_we = mem_we;
        en_cycles++;
        mem_ready = (lat >= 0 && en_cycles - 1 == lat);
        mem_rdata = mem_ready ? rdat : {$urandom, $urandom};
        if (noise) begin
          start = 1'b1; funct3 = 3'($urandom); addr = $urandom;
        end
        tick();
        start = 1'b0; mem_ready = 1'b0;
      end
    end
    tmo = !bad && (lat < 0 || lat >= MAX_WAIT);
    exp_cycles = bad ? 0 : (tmo ? MAX_WAIT : lat + 1);
    if (!st && !bad && !tmo) exp_rd = model_load(rdat, f3, off);
    n_checks++;
    if (done !== 1'b1 || en_cycles != exp_cycles) begin
      n_errors++;
      $display("FAIL %s done timing: done=%b cycles=%0d expected 1 %0d", tag, done, en_cycles, exp_cycles);
    end
    n_checks++;
    if (err !== (bad || tmo) || regwrite !== (!st && !bad && !tmo) || mem_en !== 1'b0) begin
      n_errors++;
      $display("FAIL %s resp: err=%b regwrite=%b mem_en=%b expected %b %b 0", tag, err, regwrite, mem_en, bad || tmo, !st && !bad && !tmo);
    end
    n_checks++;
    if (rd_data !== exp_rd) begin
      n_errors++;
      $display("FAIL %s rd_data: got %h expected %h", tag, rd_data, exp_rd);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL %s return idle: done=%b busy=%b expected 0 0", tag, done, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = 3'b000; addr = 32'd0;
    wr_data = 64'd0; mem_rdata = 64'd0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, err, regwrite, mem_en, mem_we} !== 6'b0 || rd_data !== 64'd0 ||
        mem_addr !== 32'd0 || mem_wstrb !== 8'd0 || mem_wdata !== 64'd0) begin
      n_errors++;
      $display("FAIL reset outputs: ctl=%b rd=%h addr=%h strb=%h wdata=%h expected all zero",
               {busy, done, err, regwrite, mem_en, mem_we}, rd_data, mem_addr, mem_wstrb, mem_wdata);
    end
    reset = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset release busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_ld();
    do_txn(1'b0, 3'b011, 32'h08, 64'd0, 64'h1122334455667788, 0, 1'b0, "ld");
    n_checks++;
    if (last_addr !== 32'h08 || rd_data !== 64'h1122334455667788) begin
      n_errors++;
      $display("FAIL ld direct: addr=%h rd=%h expected 00000008 1122334455667788", last_addr, rd_data);
    end
  endtask

  task automatic test_lb_lbu();
    do_txn(1'b0, 3'b000, 32'h0F, 64'd0, 64'h80AA_0000_0000_0000, 1, 1'b0, "lb");
    n_checks++;
    if (rd_data !== 64'hFFFF_FFFF_FFFF_FF80) begin
      n_errors++;
      $display("FAIL lb sext: got %h expected ffffffffffffff80", rd_data);
    end
    do_txn(1'b0, 3'b100, 32'h0F, 64'd0, 64'h80AA_0000_0000_0000, 2, 1'b0, "lbu");
    n_checks++;
    if (rd_data !== 64'h80) begin
      n_errors++;
      $display("FAIL lbu zext: got %h expected 80", rd_data);
    end
  endtask

  task automatic test_store();
    logic [63:0] prev;
    prev = exp_rd;
    do_txn(1'b1, 3'b001, 32'h06, 64'hABCD, 64'hDEAD, 0, 1'b0, "sh");
    n_checks++;
    if (last_addr !== 32'h0 || last_we !== 1'b1 || last_strb !== 8'hC0 ||
        last_wdata[63:48] !== 16'hABCD || rd_data !== prev) begin
      n_errors++;
      $display("FAIL sh direct: addr=%h we=%b strb=%h wdata=%h rd=%h expected 0 1 c0 abcd.. %h",
               last_addr, last_we, last_strb, last_wdata, rd_data, prev);
    end
  endtask

  task automatic test_timeout();
    logic [63:0] prev;
    prev = exp_rd;
    do_txn(1'b0, 3'b010, 32'h10, 64'd0, 64'd0, -1, 1'b0, "timeout");
    n_checks++;
    if (en_cycles != 15 || rd_data !== prev) begin
      n_errors++;
      $display("FAIL timeout direct: cycles=%0d rd=%h expected 15 %h", en_cycles, rd_data, prev);
    end
  endtask

  task automatic test_misalign();
    do_txn(1'b0, 3'b010, 32'h02, 64'd0, 64'h0123_4567_89AB_CDEF, 0, 1'b0, "lw_mis");
`ifdef LSU_MISALIGN_TRAP_EN
    n_checks++;
    if (en_cycles != 0) begin
      n_errors++;
      $display("FAIL lw_mis trap: mem_en cycles=%0d expected 0", en_cycles);
    end
`else
    n_checks++;
    if (last_addr !== 32'h0 || rd_data !== 64'hFFFF_FFFF_89AB_CDEF) begin
      n_errors++;
      $display("FAIL lw_mis align: addr=%h rd=%h expected 0 ffffffff89abcdef", last_addr, rd_data);
    end
`endif
  endtask

  task automatic test_illegal();
    do_txn(1'b0, 3'b111, 32'h20, 64'd0, 64'd0, 0, 1'b0, "ld_illegal");
    do_txn(1'b1, 3'b100, 32'h20, 64'h55, 64'd0, 0, 1'b0, "st_illegal");
  endtask

  task automatic test_reset_mid();
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h40;
    tick();
    start = 1'b0;
    n_checks++;
    if (mem_en !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_mid pre: mem_en=%b expected 1", mem_en);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (mem_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rd_data !== 64'd0) begin
      n_errors++;
      $display("FAIL reset_mid: en=%b busy=%b done=%b rd=%h expected 0 0 0 0", mem_en, busy, done, rd_data);
    end
    exp_rd = 64'd0;
    @(posedge clk);
    #1 reset = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0 || mem_en !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid idle: busy=%b mem_en=%b expected 0 0", busy, mem_en);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      do_txn(1'(i % 2), 3'b011, 32'h100 + 32'(8 * i), {$urandom, $urandom}, {$urandom, $urandom}, i % 2, 1'b1, "b2b");
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      int lat;
      lat = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 3));
      do_txn(1'($urandom), 3'($urandom), $urandom, {$urandom, $urandom}, {$urandom, $urandom},
             lat, 1'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    test_ld();
    test_lb_lbu();
    test_store();
    test_timeout();
    test_misalign();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
